dram_cmd_scheduler: RTL and testbench
=====================================

# dram_cmd_scheduler

Buffers memory operations from the trace parser in an in-order request queue and converts each into a legal DRAM command sequence (PRE/ACT/RD/WR) under an open-page policy with per-bank open-row tracking. Sits between the parser (op_ready_s/opcode/address) and the command output logger. Enforces tRP, tRCD and tCCD spacing with a single countdown timer and back-pressures the parser through queue_full.

## Interface
- ADDRESS_WIDTH, 32, request address width
- QUEUE_DEPTH, 16, request queue entries (power of two)
- T_RP, 24, PRE to ACT spacing in clk cycles
- T_RCD, 24, ACT to RD/WR spacing in clk cycles
- T_CCD, 8, column command to next command spacing in clk cycles
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- op_ready_s  input  1  parser has a valid op this cycle
- opcode  input  parsed_op_t  READ, WRITE or IFETCH
- address  input  ADDRESS_WIDTH  byte address
- queue_full  output  1  registered; op_ready_s ignored while high
- queue_empty  output  1  registered; no pending requests
- cmd_valid  output  1  one-cycle pulse per issued command
- cmd  output  dram_cmd_t  NOP, PRE, ACT, RD, WR
- cmd_bank  output  4  target bank
- cmd_row  output  15  row (valid with ACT)
- cmd_col  output  10  column (valid with RD/WR)

## Operation
- Address map: col = address[12:3], bank = address[16:13], row = address[31:17]; address[2:0] ignored.
- Enqueue when op_ready_s && !queue_full; queue_full reflects count at clock edge, so no enqueue when full even if head pops same cycle.
- Bank table: 16 entries {open, row}; all closed after reset.
- FSM states: IDLE, PRE, PRE_WAIT, ACT, ACT_WAIT, COL, GAP.
- IDLE: if head valid: bank closed -> ACT; open and row match -> COL; open and row mismatch -> PRE.
- PRE: issue PRE to head bank, mark bank closed, load timer T_RP-1, -> PRE_WAIT; timer 0 -> ACT.
- ACT: issue ACT bank/row, record row open, load timer T_RCD-1, -> ACT_WAIT; timer 0 -> COL.
- COL: issue RD (READ, IFETCH) or WR (WRITE), pop head, load timer T_CCD-1, -> GAP; timer 0 -> IDLE.
- Exactly one command per cmd_valid pulse; cmd=NOP and cmd_valid=0 in all other cycles.
- Strict in-order service; no reordering across requests.

## Timing
- Reset values: queue_full 0, queue_empty 1, cmd_valid 0, cmd NOP, cmd_bank/row/col 0, FSM IDLE, timer 0, bank table closed.
- Enqueue to first command: request written at edge N, FSM sees head at N+1, command registered at N+2.
- Command spacing: PRE at t -> ACT at t+T_RP; ACT at t -> RD/WR at t+T_RCD; RD/WR at t -> next command no earlier than t+T_CCD+1 (one IDLE decision cycle).
- Queue pointers wrap modulo QUEUE_DEPTH; count width log2(QUEUE_DEPTH)+1.
- Simultaneous enqueue and pop: count unchanged, both take effect.
- Reset mid-operation: immediate clear of queue, timer, bank table and outputs; in-flight request discarded.

## Configuration
- DRAM_CLOSED_PAGE_EN defined: after every RD/WR, GAP expiry goes to PRE for the same bank (row closed, T_RP wait) before IDLE; bank table never hit, every request does ACT/col/PRE.
- Undefined: open-page policy as above, rows left open until conflict.

## Structure
- global_defs package: dram_cmd_t enum, address field widths/offsets, default timing constants; parsed_op_t already there.
- Sub-module request_fifo: parameterized-depth FIFO of {parsed_op_t, address} with full/empty flags; FSM, timer and bank table stay in dram_cmd_scheduler.

## Test plan
- READ 0x0002_0008 after reset -> ACT bank 0 row 1 at cycle t, RD bank 0 col 1 at t+24.
- Then READ 0x0002_0010 -> RD bank 0 col 2 exactly 9 cycles after previous RD, no ACT.
- Then WRITE 0x0004_0008 -> PRE bank 0, ACT row 2 24 cycles later, WR col 1 24 cycles after ACT.
- 20 back-to-back ops to distinct rows of bank 0 -> queue_full rises once 16 are pending, parser ops held off, all 20 commands emitted in order.
- rst_n low during ACT_WAIT -> cmd_valid 0, queue_empty 1; replaying same READ after release produces ACT again.
- DRAM_CLOSED_PAGE_EN, two READs same row -> ACT, RD, PRE, ACT, RD sequence with T_RCD/T_CCD/T_RP spacing.

Source files
------------

// File: rtl/global_defs.sv
// Shared types for the trace-driven DRAM path: parsed ops, DRAM commands,
// the address field map and default timing in clk cycles.
package global_defs;

  typedef enum logic [1:0] {
    READ   = 2'd0,
    WRITE  = 2'd1,
    IFETCH = 2'd2
  } parsed_op_t;

  typedef enum logic [2:0] {
    NOP = 3'd0,
    PRE = 3'd1,
    ACT = 3'd2,
    RD  = 3'd3,
    WR  = 3'd4
  } dram_cmd_t;

  localparam int COL_LSB   = 3;
  localparam int COL_W     = 10;
  localparam int BANK_LSB  = 13;
  localparam int BANK_W    = 4;
  localparam int ROW_LSB   = 17;
  localparam int ROW_W     = 15;
  localparam int NUM_BANKS = 1 << BANK_W;

  localparam int unsigned DEF_T_RP  = 24;
  localparam int unsigned DEF_T_RCD = 24;
  localparam int unsigned DEF_T_CCD = 8;

endpackage

// File: rtl/request_fifo.sv
// In-order request queue with registered full/empty flags; head is readable the
// cycle after the write edge. Pushes while full are dropped, pops while empty ignored.
module request_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 34
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_vld,
  input  logic [DATA_W-1:0] push_dat,
  input  logic              pop_rdy,
  output logic [DATA_W-1:0] pop_dat,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              do_push, do_pop;

  // Full is judged on the registered count only, so a same-cycle pop never frees a slot early.
  assign do_push = push_vld && !full_q;
  assign do_pop  = pop_rdy && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

  assign pop_dat = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/dram_cmd_scheduler.sv
// Turns queued parser ops into PRE/ACT/RD/WR with tRP/tRCD/tCCD spacing; first command
// two cycles after enqueue; parser held off via queue_full. DRAM_CLOSED_PAGE_EN selects closed-page.
module dram_cmd_scheduler
  import global_defs::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned QUEUE_DEPTH   = 16,
  parameter int unsigned T_RP          = DEF_T_RP,
  parameter int unsigned T_RCD         = DEF_T_RCD,
  parameter int unsigned T_CCD         = DEF_T_CCD
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     op_ready_s,
  input  parsed_op_t               opcode,
  input  logic [ADDRESS_WIDTH-1:0] address,
  output logic                     queue_full,
  output logic                     queue_empty,
  output logic                     cmd_valid,
  output dram_cmd_t                cmd,
  output logic [BANK_W-1:0]        cmd_bank,
  output logic [ROW_W-1:0]         cmd_row,
  output logic [COL_W-1:0]         cmd_col
);

  localparam int OP_W    = $bits(parsed_op_t);
  localparam int ENTRY_W = OP_W + ADDRESS_WIDTH;
  localparam int TIMER_W = 8;

  localparam logic [TIMER_W-1:0] RP_LOAD  = TIMER_W'(T_RP - 1);
  localparam logic [TIMER_W-1:0] RCD_LOAD = TIMER_W'(T_RCD - 1);
  localparam logic [TIMER_W-1:0] CCD_LOAD = TIMER_W'(T_CCD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_PRE_WAIT,
    S_ACT,
    S_ACT_WAIT,
    S_COL,
    S_GAP
  } state_t;

  logic [ENTRY_W-1:0]       head_dat;
  parsed_op_t               head_op;
  logic [ADDRESS_WIDTH-1:0] head_addr;
  logic [BANK_W-1:0]        head_bank;
  logic [ROW_W-1:0]         head_row;
  logic [COL_W-1:0]         head_col;
  logic                     unused_addr_lsbs;
  logic                     fifo_pop;
  logic [BANK_W-1:0]        pre_bank;
  logic                     wait_done;

  state_t                             state_q, state_d;
  logic [TIMER_W-1:0]                 timer_q, timer_d;
  logic [NUM_BANKS-1:0]               bank_open_q, bank_open_d;
  logic [NUM_BANKS-1:0][ROW_W-1:0]    bank_row_q, bank_row_d;
  logic                               cmd_valid_q, cmd_valid_d;
  dram_cmd_t                          cmd_q, cmd_d;
  logic [BANK_W-1:0]                  cmd_bank_q, cmd_bank_d;
  logic [ROW_W-1:0]                   cmd_row_q, cmd_row_d;
  logic [COL_W-1:0]                   cmd_col_q, cmd_col_d;
`ifdef DRAM_CLOSED_PAGE_EN
  logic [BANK_W-1:0]                  close_bank_q, close_bank_d;
`endif

  request_fifo #(
    .DEPTH  (QUEUE_DEPTH),
    .DATA_W (ENTRY_W)
  ) u_request_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (op_ready_s),
    .push_dat ({opcode, address}),
    .pop_rdy  (fifo_pop),
    .pop_dat  (head_dat),
    .full     (queue_full),
    .empty    (queue_empty)
  );

  assign head_op          = parsed_op_t'(head_dat[ADDRESS_WIDTH +: OP_W]);
  assign head_addr        = head_dat[ADDRESS_WIDTH-1:0];
  assign head_col         = head_addr[COL_LSB  +: COL_W];
  assign head_bank        = head_addr[BANK_LSB +: BANK_W];
  assign head_row         = head_addr[ROW_LSB  +: ROW_W];
  assign unused_addr_lsbs = ^head_addr[COL_LSB-1:0];

`ifdef DRAM_CLOSED_PAGE_EN
  assign pre_bank = close_bank_q;
`else
  assign pre_bank = head_bank;
`endif

  // Waits end one cycle early so the next command registers exactly T cycles after the last.
  assign wait_done = (timer_q <= TIMER_W'(1));

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bank_open_d = bank_open_q;
    bank_row_d  = bank_row_q;
    cmd_valid_d = 1'b0;
    cmd_d       = NOP;
    cmd_bank_d  = cmd_bank_q;
    cmd_row_d   = cmd_row_q;
    cmd_col_d   = cmd_col_q;
    fifo_pop    = 1'b0;
`ifdef DRAM_CLOSED_PAGE_EN
    close_bank_d = close_bank_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (!queue_empty) begin
          if (!bank_open_q[head_bank])                  state_d = S_ACT;
          else if (bank_row_q[head_bank] == head_row)   state_d = S_COL;
          else                                          state_d = S_PRE;
        end
      end
      S_PRE: begin
        cmd_valid_d           = 1'b1;
        cmd_d                 = PRE;
        cmd_bank_d            = pre_bank;
        bank_open_d[pre_bank] = 1'b0;
        timer_d               = RP_LOAD;
        state_d               = S_PRE_WAIT;
      end
      S_PRE_WAIT: begin
        if (wait_done) begin
          timer_d = '0;
`ifdef DRAM_CLOSED_PAGE_EN
          state_d = S_IDLE;
`else
          state_d = S_ACT;
`endif
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      S_ACT: begin
        cmd_valid_d            = 1'b1;
        cmd_d                  = ACT;
        cmd_bank_d             = head_bank;
        cmd_row_d              = head_row;
        bank_open_d[head_bank] = 1'b1;
        bank_row_d[head_bank]  = head_row;
        timer_d                = RCD_LOAD;
        state_d                = S_ACT_WAIT;
      end
      S_ACT_WAIT: begin
        if (wait_done) begin
          timer_d = '0;
          state_d = S_COL;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      S_COL: begin
        cmd_valid_d = 1'b1;
        cmd_d       = (head_op == WRITE) ? WR : RD;
        cmd_bank_d  = head_bank;
        cmd_col_d   = head_col;
        fifo_pop    = 1'b1;
        timer_d     = CCD_LOAD;
        state_d     = S_GAP;
`ifdef DRAM_CLOSED_PAGE_EN
        close_bank_d = head_bank;
`endif
      end
      S_GAP: begin
        if (wait_done) begin
          timer_d = '0;
`ifdef DRAM_CLOSED_PAGE_EN
          state_d = S_PRE;
`else
          state_d = S_IDLE;
`endif
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      bank_open_q <= '0;
      bank_row_q  <= '0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= NOP;
      cmd_bank_q  <= '0;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
`ifdef DRAM_CLOSED_PAGE_EN
      close_bank_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bank_open_q <= bank_open_d;
      bank_row_q  <= bank_row_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      cmd_bank_q  <= cmd_bank_d;
      cmd_row_q   <= cmd_row_d;
      cmd_col_q   <= cmd_col_d;
`ifdef DRAM_CLOSED_PAGE_EN
      close_bank_q <= close_bank_d;
`endif
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd       = cmd_q;
  assign cmd_bank  = cmd_bank_q;
  assign cmd_row   = cmd_row_q;
  assign cmd_col   = cmd_col_q;

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Directed bench for dram_cmd_scheduler (open-page build) with a command scoreboard
// and a small bank-state model that predicts PRE/ACT/column sequences.
module tb_dram_cmd_scheduler;
  import global_defs::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_ready_s;
  parsed_op_t  opcode;
  logic [31:0] address;
  logic        queue_full, queue_empty, cmd_valid;
  dram_cmd_t   cmd;
  logic [3:0]  cmd_bank;
  logic [14:0] cmd_row;
  logic [9:0]  cmd_col;

  dram_cmd_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_ready_s  (op_ready_s),
    .opcode      (opcode),
    .address     (address),
    .queue_full  (queue_full),
    .queue_empty (queue_empty),
    .cmd_valid   (cmd_valid),
    .cmd         (cmd),
    .cmd_bank    (cmd_bank),
    .cmd_row     (cmd_row),
    .cmd_col     (cmd_col)
  );

  always #5 clk = ~clk;

  typedef struct {
    dram_cmd_t   cmd;
    logic [3:0]  bank;
    logic [14:0] row;
    logic [9:0]  col;
  } exp_t;

  exp_t        exp_q[$];
  dram_cmd_t   log_cmd[$];
  int          log_cyc[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          accepted = 0;
  int          popped = 0;
  int          n_act = 0;
  bit          full_seen = 1'b0;
  int          pend_at_full = -1;
  bit          m_open[16];
  logic [14:0] m_row[16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input dram_cmd_t c, input logic [3:0] b,
                              input logic [14:0] r, input logic [9:0] col);
    exp_t e;
    e.cmd = c; e.bank = b; e.row = r; e.col = col;
    return e;
  endfunction

  task automatic model_push(input parsed_op_t op, input logic [31:0] addr);
    logic [3:0]  b;
    logic [14:0] r;
    logic [9:0]  c;
    b = addr[16:13]; r = addr[31:17]; c = addr[12:3];
    if (m_open[b] && m_row[b] != r) exp_q.push_back(mk(PRE, b, 15'd0, 10'd0));
    if (!m_open[b] || m_row[b] != r) exp_q.push_back(mk(ACT, b, r, 10'd0));
    m_open[b] = 1'b1;
    m_row[b]  = r;
    exp_q.push_back(mk((op == WRITE) ? WR : RD, b, 15'd0, c));
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_open[i] = 1'b0;
      m_row[i]  = '0;
    end
  endtask

  // Presents one op and holds it until the DUT accepts it on a clock edge.
  task automatic send_op(input parsed_op_t op, input logic [31:0] addr);
    int waited = 0;
    @(negedge clk);
    op_ready_s = 1'b1;
    opcode     = op;
    address    = addr;
    while (queue_full && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    chk("send_accept_not_full", 64'(queue_full), 64'd0);
    model_push(op, addr);
    @(posedge clk);
    #1;
    accepted++;
  endtask

  task automatic idle_parser();
    @(negedge clk);
    op_ready_s = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !queue_empty) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_budget", 64'(n < 5000), 64'd1);
    repeat (12) @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (cmd_valid) begin
        log_cmd.push_back(cmd);
        log_cyc.push_back(cyc);
        if (cmd == ACT) n_act++;
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          chk("cmd", cmd, e.cmd);
          chk("cmd_bank", cmd_bank, e.bank);
          if (e.cmd == ACT) chk("cmd_row", cmd_row, e.row);
          if (e.cmd == RD || e.cmd == WR) chk("cmd_col", cmd_col, e.col);
        end
        if (cmd == RD || cmd == WR) popped++;
      end else begin
        chk("nop_when_not_valid", cmd, NOP);
      end
      chk("queue_full_flag", 64'(queue_full), 64'((accepted - popped) == 16));
      chk("queue_empty_flag", 64'(queue_empty), 64'((accepted - popped) == 0));
      if (queue_full && !full_seen) begin
        full_seen    = 1'b1;
        pend_at_full = accepted - popped;
      end
    end
  end

  initial begin
    int t_enq, base, acc0, a0, n;
    rst_n      = 1'b0;
    op_ready_s = 1'b0;
    opcode     = READ;
    address    = '0;
    model_clear();

    repeat (3) @(negedge clk);
    chk("rst_queue_full", 64'(queue_full), 64'd0);
    chk("rst_queue_empty", 64'(queue_empty), 64'd1);
    chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("rst_cmd", cmd, NOP);
    chk("rst_cmd_bank", cmd_bank, 64'd0);
    chk("rst_cmd_row", cmd_row, 64'd0);
    chk("rst_cmd_col", cmd_col, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Miss, page hit, then row conflict on bank 0.
    send_op(READ, 32'h0002_0008);
    t_enq = cyc;
    send_op(READ, 32'h0002_0010);
    send_op(WRITE, 32'h0004_0008);
    idle_parser();
    drain();
    chk("A_cmd_count", 64'(log_cmd.size()), 64'd6);
    if (log_cmd.size() == 6) begin
      chk("A_enq_to_act", 64'(log_cyc[0] - t_enq), 64'd2);
      chk("A_act_to_rd", 64'(log_cyc[1] - log_cyc[0]), 64'd24);
      chk("A_rd_to_rd", 64'(log_cyc[2] - log_cyc[1]), 64'd9);
      chk("A_rd_to_pre", 64'(log_cyc[3] - log_cyc[2]), 64'd9);
      chk("A_pre_to_act", 64'(log_cyc[4] - log_cyc[3]), 64'd24);
      chk("A_act_to_wr", 64'(log_cyc[5] - log_cyc[4]), 64'd24);
    end

    // 20 back-to-back row conflicts fill the queue and exercise pointer wrap.
    base = log_cmd.size();
    acc0 = accepted;
    for (int i = 0; i < 20; i++) begin
      parsed_op_t op;
      case (i % 3)
        0:       op = READ;
        1:       op = WRITE;
        default: op = IFETCH;
      endcase
      send_op(op, {15'(10 + i), 4'd0, 10'(i), 3'd0});
    end
    idle_parser();
    drain();
    chk("B_accepted", 64'(accepted - acc0), 64'd20);
    chk("B_cmd_count", 64'(log_cmd.size() - base), 64'd60);
    chk("B_full_seen", 64'(full_seen), 64'd1);
    chk("B_pending_at_full", 64'(pend_at_full), 64'd16);
    chk("B_full_cleared", 64'(queue_full), 64'd0);
    if (log_cmd.size() - base == 60)
      chk("B_pre_to_act", 64'(log_cyc[base + 1] - log_cyc[base]), 64'd24);

    // Reset while waiting out tRCD; the request and open-row state are lost.
    a0 = n_act;
    send_op(READ, 32'h0002_0008);
    idle_parser();
    n = 0;
    while (n_act == a0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("C_act_before_reset", 64'(n_act - a0), 64'd1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    model_clear();
    accepted = 0;
    popped   = 0;
    repeat (3) @(negedge clk);
    chk("C_rst_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("C_rst_queue_empty", 64'(queue_empty), 64'd1);
    chk("C_rst_cmd", cmd, NOP);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    a0 = log_cmd.size();
    send_op(READ, 32'h0002_0008);
    send_op(READ, 32'h0006_a038);
    idle_parser();
    drain();
    chk("C_replay_count", 64'(log_cmd.size() - a0), 64'd4);
    if (log_cmd.size() - a0 == 4) begin
      chk("C_replay_act", log_cmd[a0], ACT);
      chk("C_replay_rd", log_cmd[a0 + 1], RD);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
